// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory and decode-side signals of the fetch unit
interface fetch_unit_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic [15:0] ins;
    logic [15:0] ext;
    logic        ins_en;
    logic [15:0] ins_pc;
    logic        dec_ready;
    logic        redirect;
    logic [15:0] redirect_pc;

    modport master (
        output mem_req, mem_addr, ins, ext, ins_en, ins_pc,
        input  mem_ack, mem_data, dec_ready, redirect, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, ins, ext, ins_en, ins_pc,
        output mem_ack, mem_data, dec_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit
// Fetches one instruction word plus an optional extension word (bit 15 set) and hands both to decode.
module fetch_unit (
    input  logic          cpu_clk,
    input  logic          cpu_rst,
    fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        FETCH_INS = 2'd0,
        FETCH_EXT = 2'd1,
        VALID     = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] fpc_q, fpc_d;
    logic [15:0] ins_q, ins_d;
    logic [15:0] ext_q, ext_d;
    logic [15:0] ins_pc_q, ins_pc_d;
    logic        run_q, run_d;

    logic        mem_req;
    logic        ack_take;

    // run_q holds the request low until the first edge after reset is released.
    assign mem_req  = run_q && (state_q != VALID);
    assign ack_take = mem_req && bus.mem_ack && !bus.redirect;

    always_comb begin
        state_d  = state_q;
        fpc_d    = fpc_q;
        ins_d    = ins_q;
        ext_d    = ext_q;
        ins_pc_d = ins_pc_q;
        run_d    = 1'b1;

        case (state_q)
            FETCH_INS: begin
                if (ack_take) begin
                    ins_d    = bus.mem_data;
                    ins_pc_d = fpc_q;
                    fpc_d    = fpc_q + 16'd1;
                    if (bus.mem_data[15]) begin
                        state_d = FETCH_EXT;
                    end else begin
                        ext_d   = 16'h0000;
                        state_d = VALID;
                    end
                end
            end
            FETCH_EXT: begin
                if (ack_take) begin
                    ext_d   = bus.mem_data;
                    fpc_d   = fpc_q + 16'd1;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (bus.dec_ready) begin
                    state_d = FETCH_INS;
                end
            end
            default: begin
                state_d = FETCH_INS;
            end
        endcase

        // A redirect overrides everything, including a decode transfer in the same cycle.
        if (bus.redirect) begin
            fpc_d   = bus.redirect_pc;
            state_d = FETCH_INS;
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q  <= FETCH_INS;
            fpc_q    <= 16'h0000;
            ins_q    <= 16'h0000;
            ext_q    <= 16'h0000;
            ins_pc_q <= 16'h0000;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            ins_q    <= ins_d;
            ext_q    <= ext_d;
            ins_pc_q <= ins_pc_d;
            run_q    <= run_d;
        end
    end

    assign bus.mem_req  = mem_req;
    assign bus.mem_addr = fpc_q;
    assign bus.ins      = ins_q;
    assign bus.ext      = ext_q;
    assign bus.ins_pc   = ins_pc_q;
    assign bus.ins_en   = (state_q == VALID);

endmodule
